ahb3lite_mem_slave: RTL and testbench

AHB-Lite word-memory responder: the slave end of the DMA write path whose writes the CPU-side verifier checks. Accepts NONSEQ/SEQ transfers from the DMA master, inserts a parameterised number of wait states, and stores write data in an internal word array. Drives the memory-write tap (mem_WR_addr, mem_write_flag, HWDATA_toMem) consumed by the verifier. Returns read data and a two-cycle ERROR response for out-of-range addresses.

---
 rtl/ahb3lite_pkg.sv | 22 ++
 rtl/ahb3lite_sp_ram.sv | 23 ++
 rtl/ahb3lite_mem_slave.sv | 119 +++++++++++
 tb/tb_ahb3lite_mem_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types: transfer encoding, memory-slave FSM states and response codes.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } slave_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_sp_ram.sv
// DEPTH x 32 single-port word array: synchronous write, combinational read.
module ahb3lite_sp_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB-Lite word-memory slave with programmable wait states, two-cycle ERROR for
// out-of-range addresses and a write tap for the downstream verifier.
module ahb3lite_mem_slave import ahb3lite_pkg::*; #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  HTRANS_state HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] mem_WR_addr,
    output logic        mem_write_flag,
    output logic [31:0] HWDATA_toMem,
    output logic [15:0] wr_count
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    slave_state_t state_q, state_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic         write_q, write_d;
    logic [15:0]  wr_count_q, wr_count_d;
    logic [31:0]  haddr_q;
    logic [AW-1:0] idx_q;

    logic [31:0]  offset;
    logic         in_range;
    logic         accept;
    logic         commit;
    logic [31:0]  rdata;

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    assign offset   = HADDR - BASE_ADDR;
    assign in_range = offset < 32'(DEPTH);
    assign accept   = HSEL && HREADY && HREADYOUT && (HTRANS == NONSEQ || HTRANS == SEQ);
    assign commit   = (state_q == S_DATA) && write_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        write_d    = write_q;
        wr_count_d = commit ? wr_count_q + 16'd1 : wr_count_q;
        case (state_q)
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = S_DATA;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    write_d = HWRITE;
                    if (!in_range) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            write_q    <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Address-phase capture; these are only consumed while a data phase is live.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            haddr_q <= HADDR;
            idx_q   <= offset[AW-1:0];
        end
    end

    ahb3lite_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (commit),
        .addr_i  (idx_q),
        .wdata_i (HWDATA),
        .rdata_o (rdata)
    );

    assign HREADYOUT      = !(state_q == S_WAIT || state_q == S_ERR1);
    assign HRESP          = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA         = (state_q == S_DATA && !write_q) ? rdata : 32'h0;
    assign mem_write_flag = commit;
    assign mem_WR_addr    = commit ? haddr_q : 32'h0;
    assign HWDATA_toMem   = commit ? HWDATA : 32'h0;
    assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench: one slave with zero wait states (a_*) and one with two (b_*).
module tb_ahb3lite_mem_slave;
    import ahb3lite_pkg::*;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    logic        a_rst, a_sel, a_write, a_ready, a_resp, a_flag;
    logic [31:0] a_addr, a_wdata, a_rdata, a_wraddr, a_tomem;
    logic [15:0] a_cnt;
    HTRANS_state a_trans;

    logic        b_rst, b_sel, b_write, b_ready, b_resp, b_flag;
    logic [31:0] b_addr, b_wdata, b_rdata, b_wraddr, b_tomem;
    logic [15:0] b_cnt;
    HTRANS_state b_trans;

    ahb3lite_mem_slave #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESET(a_rst), .HSEL(a_sel), .HADDR(a_addr), .HTRANS(a_trans),
        .HWRITE(a_write), .HWDATA(a_wdata), .HREADY(a_ready), .HREADYOUT(a_ready),
        .HRESP(a_resp), .HRDATA(a_rdata), .mem_WR_addr(a_wraddr), .mem_write_flag(a_flag),
        .HWDATA_toMem(a_tomem), .wr_count(a_cnt)
    );

    ahb3lite_mem_slave #(.DEPTH(64), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
        .HCLK(HCLK), .HRESET(b_rst), .HSEL(b_sel), .HADDR(b_addr), .HTRANS(b_trans),
        .HWRITE(b_write), .HWDATA(b_wdata), .HREADY(b_ready), .HREADYOUT(b_ready),
        .HRESP(b_resp), .HRDATA(b_rdata), .mem_WR_addr(b_wraddr), .mem_write_flag(b_flag),
        .HWDATA_toMem(b_tomem), .wr_count(b_cnt)
    );

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic a_ap(input HTRANS_state t, input logic w, input logic [31:0] ad, input logic [31:0] wd);
        a_sel = 1'b1; a_trans = t; a_write = w; a_addr = ad; a_wdata = wd;
    endtask

    task automatic b_ap(input HTRANS_state t, input logic w, input logic [31:0] ad, input logic [31:0] wd);
        b_sel = 1'b1; b_trans = t; b_write = w; b_addr = ad; b_wdata = wd;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_ap(IDLE, 1'b0, 32'h0, 32'hFFFF_FFFF);
        b_ap(IDLE, 1'b0, 32'h0, 32'hFFFF_FFFF);
        #2;
        n_total++; if (a_ready !== 1'b1) $display("FAIL rst_hreadyout: got %b want 1", a_ready); else n_pass++;
        n_total++; if (a_resp !== 1'b0) $display("FAIL rst_hresp: got %b want 0", a_resp); else n_pass++;
        n_total++; if (a_rdata !== 32'h0) $display("FAIL rst_hrdata: got %h want 0", a_rdata); else n_pass++;
        n_total++; if (a_flag !== 1'b0) $display("FAIL rst_flag: got %b want 0", a_flag); else n_pass++;
        n_total++; if (a_wraddr !== 32'h0) $display("FAIL rst_wraddr: got %h want 0", a_wraddr); else n_pass++;
        n_total++; if (a_tomem !== 32'h0) $display("FAIL rst_tomem: got %h want 0", a_tomem); else n_pass++;
        n_total++; if (a_cnt !== 16'h0) $display("FAIL rst_count: got %h want 0", a_cnt); else n_pass++;
        n_total++; if (b_ready !== 1'b1) $display("FAIL rst_b_hreadyout: got %b want 1", b_ready); else n_pass++;
        n_total++; if (b_cnt !== 16'h0) $display("FAIL rst_b_count: got %h want 0", b_cnt); else n_pass++;
        cyc(); cyc();
        a_rst = 1'b0; b_rst = 1'b0;
        cyc();
    endtask

    task automatic test_write_burst();
        a_ap(NONSEQ, 1'b1, 32'h10, 32'h0); cyc();
        a_ap(SEQ, 1'b1, 32'h0F, 32'd5); smp();
        n_total++; if (a_flag !== 1'b1) $display("FAIL burst_flag0: got %b want 1", a_flag); else n_pass++;
        n_total++; if (a_wraddr !== 32'h10) $display("FAIL burst_addr0: got %h want 10", a_wraddr); else n_pass++;
        n_total++; if (a_tomem !== 32'd5) $display("FAIL burst_data0: got %h want 5", a_tomem); else n_pass++;
        n_total++; if (a_ready !== 1'b1) $display("FAIL burst_ready0: got %b want 1", a_ready); else n_pass++;
        cyc();
        a_ap(SEQ, 1'b1, 32'h0E, 32'd6); smp();
        n_total++; if (a_flag !== 1'b1) $display("FAIL burst_flag1: got %b want 1", a_flag); else n_pass++;
        n_total++; if (a_wraddr !== 32'h0F) $display("FAIL burst_addr1: got %h want 0f", a_wraddr); else n_pass++;
        n_total++; if (a_tomem !== 32'd6) $display("FAIL burst_data1: got %h want 6", a_tomem); else n_pass++;
        cyc();
        a_ap(IDLE, 1'b0, 32'h0, 32'd7); smp();
        n_total++; if (a_flag !== 1'b1) $display("FAIL burst_flag2: got %b want 1", a_flag); else n_pass++;
        n_total++; if (a_wraddr !== 32'h0E) $display("FAIL burst_addr2: got %h want 0e", a_wraddr); else n_pass++;
        n_total++; if (a_tomem !== 32'd7) $display("FAIL burst_data2: got %h want 7", a_tomem); else n_pass++;
        cyc();
        smp();
        n_total++; if (a_flag !== 1'b0) $display("FAIL burst_flag_end: got %b want 0", a_flag); else n_pass++;
        n_total++; if (a_cnt !== 16'd3) $display("FAIL burst_count: got %0d want 3", a_cnt); else n_pass++;
        a_ap(NONSEQ, 1'b0, 32'h10, 32'h0); cyc();
        a_ap(SEQ, 1'b0, 32'h0E, 32'h0); smp();
        n_total++; if (a_rdata !== 32'd5) $display("FAIL burst_rd10: got %h want 5", a_rdata); else n_pass++;
        n_total++; if (a_flag !== 1'b0) $display("FAIL burst_rd_flag: got %b want 0", a_flag); else n_pass++;
        cyc();
        a_ap(IDLE, 1'b0, 32'h0, 32'h0); smp();
        n_total++; if (a_rdata !== 32'd7) $display("FAIL burst_rd0e: got %h want 7", a_rdata); else n_pass++;
        cyc();
    endtask

    task automatic test_wait_states();
        b_ap(NONSEQ, 1'b1, 32'h3, 32'h0); cyc();
        // Master holds the next (read) address phase while HREADY is low.
        b_ap(NONSEQ, 1'b0, 32'h3, 32'hA5A5_0001); smp();
        n_total++; if (b_ready !== 1'b0) $display("FAIL ws_w1_ready: got %b want 0", b_ready); else n_pass++;
        n_total++; if (b_flag !== 1'b0) $display("FAIL ws_w1_flag: got %b want 0", b_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (b_ready !== 1'b0) $display("FAIL ws_w2_ready: got %b want 0", b_ready); else n_pass++;
        n_total++; if (b_flag !== 1'b0) $display("FAIL ws_w2_flag: got %b want 0", b_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (b_ready !== 1'b1) $display("FAIL ws_d_ready: got %b want 1", b_ready); else n_pass++;
        n_total++; if (b_flag !== 1'b1) $display("FAIL ws_d_flag: got %b want 1", b_flag); else n_pass++;
        n_total++; if (b_wraddr !== 32'h3) $display("FAIL ws_d_addr: got %h want 3", b_wraddr); else n_pass++;
        n_total++; if (b_tomem !== 32'hA5A5_0001) $display("FAIL ws_d_data: got %h want a5a50001", b_tomem); else n_pass++;
        n_total++; if (b_resp !== 1'b0) $display("FAIL ws_d_resp: got %b want 0", b_resp); else n_pass++;
        cyc();
        b_ap(IDLE, 1'b0, 32'h0, 32'h0); smp();
        n_total++; if (b_ready !== 1'b0) $display("FAIL ws_rw1_ready: got %b want 0", b_ready); else n_pass++;
        n_total++; if (b_rdata !== 32'h0) $display("FAIL ws_rw1_rdata: got %h want 0", b_rdata); else n_pass++;
        cyc(); smp();
        n_total++; if (b_ready !== 1'b0) $display("FAIL ws_rw2_ready: got %b want 0", b_ready); else n_pass++;
        cyc(); smp();
        n_total++; if (b_ready !== 1'b1) $display("FAIL ws_rd_ready: got %b want 1", b_ready); else n_pass++;
        n_total++; if (b_rdata !== 32'hA5A5_0001) $display("FAIL ws_rd_data: got %h want a5a50001", b_rdata); else n_pass++;
        n_total++; if (b_flag !== 1'b0) $display("FAIL ws_rd_flag: got %b want 0", b_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (b_cnt !== 16'd1) $display("FAIL ws_count: got %0d want 1", b_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_error();
        a_ap(NONSEQ, 1'b1, 32'h3F, 32'h0); cyc();
        a_ap(NONSEQ, 1'b1, 32'h40, 32'h3F3F); smp();
        n_total++; if (a_flag !== 1'b1) $display("FAIL err_last_flag: got %b want 1", a_flag); else n_pass++;
        n_total++; if (a_wraddr !== 32'h3F) $display("FAIL err_last_addr: got %h want 3f", a_wraddr); else n_pass++;
        n_total++; if (a_resp !== 1'b0) $display("FAIL err_last_resp: got %b want 0", a_resp); else n_pass++;
        cyc();
        a_ap(IDLE, 1'b0, 32'h0, 32'h4040); smp();
        n_total++; if (a_ready !== 1'b0) $display("FAIL err1_ready: got %b want 0", a_ready); else n_pass++;
        n_total++; if (a_resp !== 1'b1) $display("FAIL err1_resp: got %b want 1", a_resp); else n_pass++;
        n_total++; if (a_flag !== 1'b0) $display("FAIL err1_flag: got %b want 0", a_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (a_ready !== 1'b1) $display("FAIL err2_ready: got %b want 1", a_ready); else n_pass++;
        n_total++; if (a_resp !== 1'b1) $display("FAIL err2_resp: got %b want 1", a_resp); else n_pass++;
        n_total++; if (a_flag !== 1'b0) $display("FAIL err2_flag: got %b want 0", a_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (a_resp !== 1'b0) $display("FAIL err_after_resp: got %b want 0", a_resp); else n_pass++;
        n_total++; if (a_cnt !== 16'd4) $display("FAIL err_count: got %0d want 4", a_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_busy();
        int pulses;
        pulses = 0;
        a_ap(NONSEQ, 1'b1, 32'h20, 32'h0); cyc();
        a_ap(BUSY, 1'b1, 32'h21, 32'h11); smp();
        pulses += int'(a_flag);
        n_total++; if (a_wraddr !== 32'h20) $display("FAIL busy_addr0: got %h want 20", a_wraddr); else n_pass++;
        n_total++; if (a_tomem !== 32'h11) $display("FAIL busy_data0: got %h want 11", a_tomem); else n_pass++;
        cyc();
        a_ap(SEQ, 1'b1, 32'h21, 32'hDEAD); smp();
        pulses += int'(a_flag);
        n_total++; if (a_flag !== 1'b0) $display("FAIL busy_slot_flag: got %b want 0", a_flag); else n_pass++;
        n_total++; if (a_ready !== 1'b1) $display("FAIL busy_slot_ready: got %b want 1", a_ready); else n_pass++;
        n_total++; if (a_resp !== 1'b0) $display("FAIL busy_slot_resp: got %b want 0", a_resp); else n_pass++;
        cyc();
        a_ap(IDLE, 1'b0, 32'h0, 32'h22); smp();
        pulses += int'(a_flag);
        n_total++; if (a_wraddr !== 32'h21) $display("FAIL busy_addr1: got %h want 21", a_wraddr); else n_pass++;
        n_total++; if (a_tomem !== 32'h22) $display("FAIL busy_data1: got %h want 22", a_tomem); else n_pass++;
        cyc(); smp();
        pulses += int'(a_flag);
        n_total++; if (pulses !== 2) $display("FAIL busy_pulses: got %0d want 2", pulses); else n_pass++;
        n_total++; if (a_cnt !== 16'd6) $display("FAIL busy_count: got %0d want 6", a_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_back_to_back();
        a_ap(NONSEQ, 1'b1, 32'h5, 32'h0); cyc();
        a_ap(NONSEQ, 1'b0, 32'h5, 32'h1234_5678); smp();
        n_total++; if (a_flag !== 1'b1) $display("FAIL raw_flag: got %b want 1", a_flag); else n_pass++;
        cyc();
        a_ap(IDLE, 1'b0, 32'h0, 32'h0); smp();
        n_total++; if (a_rdata !== 32'h1234_5678) $display("FAIL raw_rdata: got %h want 12345678", a_rdata); else n_pass++;
        n_total++; if (a_flag !== 1'b0) $display("FAIL raw_rd_flag: got %b want 0", a_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (a_cnt !== 16'd7) $display("FAIL raw_count: got %0d want 7", a_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_reset_mid();
        b_ap(NONSEQ, 1'b1, 32'h7, 32'h0); cyc();
        b_ap(IDLE, 1'b0, 32'h0, 32'h7777); cyc(); cyc(); cyc();
        smp();
        n_total++; if (b_cnt !== 16'd2) $display("FAIL rmid_pre_count: got %0d want 2", b_cnt); else n_pass++;
        cyc();
        b_ap(NONSEQ, 1'b1, 32'h7, 32'h0); cyc();
        b_ap(IDLE, 1'b0, 32'h0, 32'h0BAD);
        #1;
        n_total++; if (b_ready !== 1'b0) $display("FAIL rmid_in_wait: got %b want 0", b_ready); else n_pass++;
        b_rst = 1'b1;
        #1;
        n_total++; if (b_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", b_ready); else n_pass++;
        n_total++; if (b_resp !== 1'b0) $display("FAIL rmid_resp: got %b want 0", b_resp); else n_pass++;
        n_total++; if (b_flag !== 1'b0) $display("FAIL rmid_flag: got %b want 0", b_flag); else n_pass++;
        n_total++; if (b_wraddr !== 32'h0) $display("FAIL rmid_wraddr: got %h want 0", b_wraddr); else n_pass++;
        n_total++; if (b_tomem !== 32'h0) $display("FAIL rmid_tomem: got %h want 0", b_tomem); else n_pass++;
        n_total++; if (b_cnt !== 16'h0) $display("FAIL rmid_count: got %0d want 0", b_cnt); else n_pass++;
        cyc();
        b_rst = 1'b0;
        cyc();
        b_ap(NONSEQ, 1'b0, 32'h7, 32'h0); cyc();
        b_ap(IDLE, 1'b0, 32'h0, 32'h0); cyc(); cyc();
        smp();
        n_total++; if (b_ready !== 1'b1) $display("FAIL rmid_rd_ready: got %b want 1", b_ready); else n_pass++;
        n_total++; if (b_rdata !== 32'h7777) $display("FAIL rmid_array: got %h want 7777", b_rdata); else n_pass++;
        n_total++; if (b_cnt !== 16'h0) $display("FAIL rmid_count_after: got %0d want 0", b_cnt); else n_pass++;
        cyc();
    endtask

    task automatic test_count_wrap();
        a_rst = 1'b1;
        #1;
        n_total++; if (a_cnt !== 16'h0) $display("FAIL wrap_reset: got %0d want 0", a_cnt); else n_pass++;
        cyc();
        a_rst = 1'b0;
        cyc();
        for (int k = 0; k < 65535; k++) begin
            a_ap(NONSEQ, 1'b1, 32'(k % 64), 32'(k));
            cyc();
        end
        a_ap(IDLE, 1'b0, 32'h0, 32'h0); cyc();
        smp();
        n_total++; if (a_cnt !== 16'hFFFF) $display("FAIL wrap_full: got %h want ffff", a_cnt); else n_pass++;
        cyc();
        a_ap(NONSEQ, 1'b1, 32'h9, 32'h0); cyc();
        a_ap(IDLE, 1'b0, 32'h0, 32'h99); smp();
        n_total++; if (a_flag !== 1'b1) $display("FAIL wrap_flag: got %b want 1", a_flag); else n_pass++;
        cyc(); smp();
        n_total++; if (a_cnt !== 16'h0) $display("FAIL wrap_zero: got %h want 0", a_cnt); else n_pass++;
        cyc();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_wait_states();
        test_error();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
